// File: rtl/cpu_run_ctrl.sv
// Run/step controller for the 3-bit-opcode CPU: synchronizes and debounces the board
// controls, gates the CPU with a clock enable, and counts enabled cycles and instructions.
module cpu_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16,
    parameter bit STEP_INSTR      = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             step_n,
    input  logic             run_sw,
    input  logic             clear_sw,
    input  logic             halt_in,
    input  logic             instr_done,
    output logic             cpu_en,
    output logic             cpu_rst,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_STEP   = 2'b10;
    localparam logic [1:0] ST_HALTED = 2'b11;

    localparam int             DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Bit order {clear, run, step}; step idles high because the button is active-low.
    localparam logic [2:0] SYNC_PRESET = 3'b001;

    logic [2:0] raw_vec;
    logic [2:0] sync_vec;
    logic       step_s;
    logic       run_s;
    logic       clear_s;

    assign raw_vec = {clear_sw, run_sw, step_n};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    meta_reg <= SYNC_PRESET[gi];
                    sync_reg <= SYNC_PRESET[gi];
                end else begin
                    meta_reg <= raw_vec[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_vec[gi] = sync_reg;
        end
    endgenerate

    assign step_s  = sync_vec[0];
    assign run_s   = sync_vec[1];
    assign clear_s = sync_vec[2];

    // Debounce: the level only follows step_s after DEBOUNCE_CYCLES consecutive mismatches.
    logic            db_reg;
    logic            db_next;
    logic [DB_W-1:0] db_cnt_reg;
    logic [DB_W-1:0] db_cnt_next;
    logic            press_reg;
    logic            press_next;

    always_comb begin
        db_next     = db_reg;
        db_cnt_next = db_cnt_reg;
        if (step_s == db_reg) begin
            db_cnt_next = '0;
        end else if (db_cnt_reg == DB_LAST) begin
            db_next     = step_s;
            db_cnt_next = '0;
        end else begin
            db_cnt_next = db_cnt_reg + DB_W'(1);
        end
        press_next = db_reg & ~db_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_reg     <= 1'b1;
            db_cnt_reg <= '0;
            press_reg  <= 1'b0;
        end else begin
            db_reg     <= db_next;
            db_cnt_reg <= db_cnt_next;
            press_reg  <= press_next;
        end
    end

    // Datapath reset: follows clear_s and is stretched by two cycles after it falls.
    logic [1:0] rst_hold_reg;
    logic [1:0] rst_hold_next;
    logic       cpu_rst_reg;
    logic       cpu_rst_next;

    always_comb begin
        rst_hold_next = rst_hold_reg;
        if (clear_s) begin
            rst_hold_next = 2'd2;
        end else if (rst_hold_reg != 2'd0) begin
            rst_hold_next = rst_hold_reg - 2'd1;
        end
        cpu_rst_next = clear_s | (rst_hold_reg != 2'd0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_hold_reg <= 2'd0;
            cpu_rst_reg  <= 1'b1;
        end else begin
            rst_hold_reg <= rst_hold_next;
            cpu_rst_reg  <= cpu_rst_next;
        end
    end

    logic [1:0] state_reg;
    logic [1:0] state_next;

    always_comb begin
        state_next = state_reg;
        if (clear_s) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cpu_rst_reg) begin
                        state_next = ST_IDLE;
                    end else if (run_s) begin
                        state_next = ST_RUN;
                    end else if (press_reg) begin
                        state_next = ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (halt_in) begin
                        state_next = ST_HALTED;
                    end else if (!run_s) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_STEP: begin
                    if (halt_in) begin
                        state_next = ST_HALTED;
                    end else if (!STEP_INSTR || instr_done) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_HALTED;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Enable is combinational so a halt freezes the CPU in the very cycle it appears.
    logic en_comb;
    assign en_comb = ((state_reg == ST_RUN) || (state_reg == ST_STEP)) && !halt_in && !clear_s;

    logic [CNT_W-1:0] cycle_cnt_reg;
    logic [CNT_W-1:0] cycle_cnt_next;
    logic [CNT_W-1:0] instr_cnt_reg;
    logic [CNT_W-1:0] instr_cnt_next;

    always_comb begin
        cycle_cnt_next = cycle_cnt_reg;
        instr_cnt_next = instr_cnt_reg;
        if (clear_s) begin
            cycle_cnt_next = '0;
            instr_cnt_next = '0;
        end else begin
            if (en_comb && (cycle_cnt_reg != CNT_MAX)) begin
                cycle_cnt_next = cycle_cnt_reg + CNT_W'(1);
            end
            if (en_comb && instr_done && (instr_cnt_reg != CNT_MAX)) begin
                instr_cnt_next = instr_cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_cnt_reg <= '0;
            instr_cnt_reg <= '0;
        end else begin
            cycle_cnt_reg <= cycle_cnt_next;
            instr_cnt_reg <= instr_cnt_next;
        end
    end

    assign cpu_en      = en_comb;
    assign cpu_rst     = cpu_rst_reg;
    assign state       = state_reg;
    assign halted      = (state_reg == ST_HALTED);
    assign cycle_count = cycle_cnt_reg;
    assign instr_count = instr_cnt_reg;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/step controller for the 3-bit-opcode CPU.
- Sits between the board inputs (switches and the active-low pushbutton) and the control unit.
- Gates the CPU with a clock enable rather than a derived clock. Supports free-run, single-instruction or single-cycle stepping, halt capture and datapath clear.
- Provides cycle and instruction counters for LED/debug display.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed before the debounced key level changes (raise for synthesis).
- CNT_W, 16, width of both counters.
- STEP_INSTR, 1, step granularity: 1 = one full instruction per press, 0 = one clock per press.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- step_n  in  1  raw pushbutton, active-low, asynchronous
- run_sw  in  1  raw run switch, asynchronous, 1 = free-run
- clear_sw  in  1  raw clear switch, asynchronous, 1 = clear
- halt_in  in  1  Halt from control unit, already synchronous to clock
- instr_done  in  1  one-cycle pulse from control unit marking the last cycle of an instruction (IRload of next fetch)
- cpu_en  out  1  clock enable to control unit and datapath
- cpu_rst  out  1  synchronous reset to control unit and datapath
- state  out  2  IDLE=00, RUN=01, STEP=10, HALTED=11
- halted  out  1  state==HALTED
- cycle_count  out  CNT_W  enabled CPU cycles
- instr_count  out  CNT_W  completed instructions

Behaviour:
- Reset values (async): state=IDLE, cpu_en=0, cpu_rst=1, halted=0, counters=0. Synchronizers preset to inactive (step_n=1, run_sw=0, clear_sw=0). Debounced level=1, debounce counter=0.
- Synchronization:
  - step_n, run_sw and clear_sw each pass through a 2-FF synchronizer: run_s, clear_s, step_s.
- Debounce on step_s:
  - Counter increments each cycle step_s != db.
  - Counter resets to 0 when step_s == db.
  - When counter == DEBOUNCE_CYCLES-1 and the values still mismatch: db<=step_s, counter<=0.
- press:
  - Registered one-cycle pulse, set on the edge where db goes 1->0.
  - Release (0->1) produces no pulse.
- FSM (registered; transitions evaluated in priority order):
  - clear_s=1, any state -> IDLE.
  - IDLE: run_s=1 -> RUN. Else press=1 -> STEP.
  - RUN: halt_in=1 -> HALTED. Else run_s=0 -> IDLE.
  - STEP: halt_in=1 -> HALTED.
    - STEP_INSTR=0: always -> IDLE after one cycle.
    - STEP_INSTR=1: instr_done=1 -> IDLE.
  - HALTED: held until clear_s=1. press and run_s are ignored.
- cpu_en is combinational: (state==RUN || state==STEP) && !halt_in && !clear_s. Halt therefore stops the CPU in the same cycle it is asserted.
- cpu_rst (registered):
  - 1 while reset or clear_s.
  - Stays 1 for exactly 2 further cycles after clear_s falls; 0 otherwise.
  - While cpu_rst=1 the FSM remains in IDLE regardless of run_s or press.
- Counters:
  - cycle_count +1 on every cycle with cpu_en=1.
  - instr_count +1 when cpu_en && instr_done.
  - Both saturate at 2^CNT_W-1; no wrap.
  - Both cleared to 0 while clear_s=1.
- Simultaneous events:
  - clear beats halt.
  - halt beats instr_done and run_s=0.
  - A press arriving in RUN or STEP is dropped, never queued.
- Reset mid-step: the step is abandoned; cpu_en=0 immediately (async).

Test Plan:
- Reset, then run_s=1: state 01 two edges after reset and sync. cpu_en=1. After 10 enabled cycles, cycle_count=10.
- With STEP_INSTR=1, DEBOUNCE_CYCLES=4:
  - Stimulus: drop step_n before edge 1, held low.
  - press is high for the cycle after edge 6.
  - state=STEP and cpu_en=1 from edge 7.
  - instr_done pulses on the 3rd enabled cycle -> state=IDLE on the next edge, instr_count=1, cycle_count=3.
- Bounce: toggle step_n 0/1 every 2 cycles for 20 cycles, then hold at 1 -> press never asserts; state stays IDLE.
- In RUN, assert halt_in -> cpu_en=0 in the same cycle, state=HALTED next edge, halted=1. A later press and run_s toggles leave the state at 11.
- From HALTED with counters nonzero, raise clear_sw for 5 cycles, then lower it:
  - state=IDLE and counters=0 while clear_s is high.
  - cpu_rst=1 throughout and for 2 cycles after clear_s falls, then 0.
  - With run_s=1, RUN is entered only after cpu_rst drops.
- CNT_W=4, run for 20 cycles -> cycle_count saturates at 15. STEP_INSTR=0 press -> exactly one cpu_en cycle, then IDLE.
